// File: rtl/prog_counter.sv
// Programmable up/down counter with prescaled tick, wrap or saturate behaviour,
// a terminal-count pulse and a sticky overflow flag.
module prog_counter #(
  parameter int WIDTH      = 8,
  parameter int PRESCALE_W = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  clr,
  input  logic                  load,
  input  logic [WIDTH-1:0]      load_val,
  input  logic                  dir,
  input  logic                  mode,
  input  logic [WIDTH-1:0]      max_val,
  input  logic [PRESCALE_W-1:0] prescale,
  output logic [WIDTH-1:0]      count,
  output logic                  tc,
  output logic                  ovf
);

  logic [PRESCALE_W-1:0] pcnt_q, pcnt_d;
  logic [WIDTH-1:0]      count_q, count_d;
  logic                  tc_q, tc_d;
  logic                  ovf_q, ovf_d;
  logic                  tick_s;

  // Prescaler: one tick every prescale+1 enabled cycles, phase frozen while en=0
  always_comb begin
    tick_s = 1'b0;
    pcnt_d = pcnt_q;
    if (clr || load) begin
      pcnt_d = '0;
    end else if (en) begin
      if (pcnt_q == prescale) begin
        tick_s = 1'b1;
        pcnt_d = '0;
      end else begin
        pcnt_d = pcnt_q + PRESCALE_W'(1);
      end
    end else begin
      pcnt_d = pcnt_q;
    end
  end

  // Count, terminal-count and overflow next state; priority clr > load > tick > hold
  always_comb begin
    count_d = count_q;
    tc_d    = 1'b0;
    ovf_d   = ovf_q;
    if (clr) begin
      count_d = '0;
      ovf_d   = 1'b0;
    end else if (load) begin
      count_d = load_val;
    end else if (tick_s) begin
      if (dir) begin
        if (count_q < max_val) begin
          count_d = count_q + WIDTH'(1);
        end else begin
          tc_d = 1'b1;
          if (mode) begin
            count_d = max_val;
          end else begin
            count_d = '0;
            ovf_d   = 1'b1;
          end
        end
      end else begin
        if (count_q == '0) begin
          tc_d = 1'b1;
          if (mode) begin
            count_d = '0;
          end else begin
            count_d = max_val;
            ovf_d   = 1'b1;
          end
        end else if (count_q > max_val) begin
          // Out-of-range value from a load: pull back to the limit
          count_d = max_val;
          if (mode) begin
            ovf_d = ovf_q;
          end else begin
            ovf_d = 1'b1;
          end
        end else begin
          count_d = count_q - WIDTH'(1);
        end
      end
    end else begin
      count_d = count_q;
    end
  end

  // State registers with asynchronous active-low reset
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pcnt_q  <= '0;
      count_q <= '0;
      tc_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      pcnt_q  <= pcnt_d;
      count_q <= count_d;
      tc_q    <= tc_d;
      ovf_q   <= ovf_d;
    end
  end

  assign count = count_q;
  assign tc    = tc_q;
  assign ovf   = ovf_q;

endmodule

// File: tb/tb_prog_counter.sv
// Scoreboard bench for prog_counter: expected count/tc/ovf are queued as each
// cycle's stimulus is driven and compared after the following rising edge.
module tb_prog_counter;

  localparam int WIDTH      = 8;
  localparam int PRESCALE_W = 4;

  logic                  clk;
  logic                  rst;
  logic                  en;
  logic                  clr;
  logic                  load;
  logic [WIDTH-1:0]      load_val;
  logic                  dir;
  logic                  mode;
  logic [WIDTH-1:0]      max_val;
  logic [PRESCALE_W-1:0] prescale;
  logic [WIDTH-1:0]      count;
  logic                  tc;
  logic                  ovf;

  typedef struct {
    string          tag;
    logic [WIDTH-1:0] exp_count;
    logic           exp_tc;
    logic           exp_ovf;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  prog_counter #(.WIDTH(WIDTH), .PRESCALE_W(PRESCALE_W)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .clr      (clr),
    .load     (load),
    .load_val (load_val),
    .dir      (dir),
    .mode     (mode),
    .max_val  (max_val),
    .prescale (prescale),
    .count    (count),
    .tc       (tc),
    .ovf      (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Queue the expectation for the coming edge, then compare after it
  task automatic step(input string tag, input int c, input logic t, input logic o);
    exp_t e;
    exp_t got;
    e.tag = tag;
    e.exp_count = WIDTH'(c);
    e.exp_tc = t;
    e.exp_ovf = o;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    got = sb_q.pop_front();
    check_val({got.tag, "_count"}, 32'(count), 32'(got.exp_count));
    check_val({got.tag, "_tc"}, 32'(tc), 32'(got.exp_tc));
    check_val({got.tag, "_ovf"}, 32'(ovf), 32'(got.exp_ovf));
  endtask

  task automatic do_clear();
    clr = 1'b1;
    step("clr", 0, 1'b0, 1'b0);
    clr = 1'b0;
  endtask

  task automatic do_load(input string tag, input int v, input logic o);
    load = 1'b1;
    load_val = WIDTH'(v);
    step(tag, v, 1'b0, o);
    load = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int wrap_cnt[7];
    int wrap_tc[7];
    int wrap_ovf[7];
    int pre_cnt[8];
    wrap_cnt = '{1, 2, 3, 4, 5, 0, 1};
    wrap_tc  = '{0, 0, 0, 0, 0, 1, 0};
    wrap_ovf = '{0, 0, 0, 0, 0, 1, 1};
    pre_cnt  = '{0, 0, 0, 1, 1, 1, 1, 2};

    rst = 1'b0; en = 1'b0; clr = 1'b0; load = 1'b0; load_val = 8'd0;
    dir = 1'b1; mode = 1'b0; max_val = 8'd5; prescale = 4'd0;
    repeat (2) @(posedge clk);
    #1;
    check_val("reset_count", 32'(count), 32'd0);
    check_val("reset_tc", 32'(tc), 32'd0);
    check_val("reset_ovf", 32'(ovf), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Basic wrap at max_val=5
    en = 1'b1;
    for (int i = 0; i < 7; i++) step("wrap", wrap_cnt[i], wrap_tc[i] != 0, wrap_ovf[i] != 0);
    do_clear();

    // Saturating down count from 2
    mode = 1'b1; dir = 1'b0;
    do_load("sat_load", 2, 1'b0);
    step("sat_dn1", 1, 1'b0, 1'b0);
    step("sat_dn0", 0, 1'b0, 1'b0);
    step("sat_hold0a", 0, 1'b1, 1'b0);
    step("sat_hold0b", 0, 1'b1, 1'b0);
    do_clear();

    // Prescaler: tick every 4th enabled cycle, phase frozen while disabled
    prescale = 4'd3; dir = 1'b1; mode = 1'b0; max_val = 8'd20;
    for (int i = 0; i < 8; i++) step("presc", pre_cnt[i], 1'b0, 1'b0);
    step("presc_ph1", 2, 1'b0, 1'b0);
    step("presc_ph2", 2, 1'b0, 1'b0);
    en = 1'b0;
    for (int i = 0; i < 5; i++) step("presc_frozen", 2, 1'b0, 1'b0);
    en = 1'b1;
    step("presc_ph3", 2, 1'b0, 1'b0);
    step("presc_resume", 3, 1'b0, 1'b0);

    // max_val=0 up/wrap: every tick wraps to 0 with tc and ovf
    prescale = 4'd0; max_val = 8'd0;
    step("max0_a", 0, 1'b1, 1'b1);
    step("max0_b", 0, 1'b1, 1'b1);

    // clr beats load in the same cycle
    clr = 1'b1; load = 1'b1; load_val = 8'd9;
    step("clr_over_load", 0, 1'b0, 1'b0);
    clr = 1'b0; load = 1'b0;

    // Out-of-range load then up/wrap
    max_val = 8'd10;
    do_load("load200", 200, 1'b0);
    step("load200_wrap", 0, 1'b1, 1'b1);
    step("load200_next", 1, 1'b0, 1'b1);
    do_clear();

    // Down/wrap: above-range value pulled to max_val, then wrap from 0
    dir = 1'b0;
    do_load("dn_load200", 200, 1'b0);
    step("dn_above", 10, 1'b0, 1'b1);
    step("dn_dec", 9, 1'b0, 1'b1);
    do_load("dn_load1", 1, 1'b1);
    step("dn_to0", 0, 1'b0, 1'b1);
    step("dn_wrap", 10, 1'b1, 1'b1);
    step("dn_after", 9, 1'b0, 1'b1);
    do_clear();

    // Up/saturate at max_val, then saturating down from above range
    dir = 1'b1; mode = 1'b1;
    do_load("usat_load", 9, 1'b0);
    step("usat_10", 10, 1'b0, 1'b0);
    step("usat_hold_a", 10, 1'b1, 1'b0);
    step("usat_hold_b", 10, 1'b1, 1'b0);
    dir = 1'b0;
    do_load("dsat_load", 200, 1'b0);
    step("dsat_above", 10, 1'b0, 1'b0);

    // Async reset mid-count at 7 with ovf set beforehand
    do_clear();
    mode = 1'b0; dir = 1'b1; max_val = 8'd0;
    step("pre_rst_ovf", 0, 1'b1, 1'b1);
    max_val = 8'd20;
    for (int i = 1; i <= 7; i++) step("pre_rst_up", i, 1'b0, 1'b1);
    #2;
    rst = 1'b0;
    #1;
    check_val("arst_count", 32'(count), 32'd0);
    check_val("arst_tc", 32'(tc), 32'd0);
    check_val("arst_ovf", 32'(ovf), 32'd0);
    @(posedge clk);
    #1;
    check_val("arst_held_count", 32'(count), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    step("post_rst1", 1, 1'b0, 1'b0);
    step("post_rst2", 2, 1'b0, 1'b0);

    check_val("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/prog_counter.md
PROG_COUNTER -- requirements
Module: prog_counter

Interface
REQ-001 SHALL have parameter WIDTH, default 8, counter width in bits (>=2).
REQ-002 SHALL have parameter PRESCALE_W, default 4, prescaler compare width in bits (>=1).
REQ-003 SHALL have port clk, input, 1, rising-edge clock.
REQ-004 SHALL have port rst, input, 1, reset: asynchronous, active-low.
REQ-005 SHALL have port en, input, 1, count enable; gates the prescaler.
REQ-006 SHALL have port clr, input, 1, synchronous clear.
REQ-007 SHALL have port load, input, 1, synchronous load strobe.
REQ-008 SHALL have port load_val, input, WIDTH, value for load.
REQ-009 SHALL have port dir, input, 1, 1 = up, 0 = down.
REQ-010 SHALL have port mode, input, 1, 0 = wrap, 1 = saturate.
REQ-011 SHALL have port max_val, input, WIDTH, upper count limit (inclusive).
REQ-012 SHALL have port prescale, input, PRESCALE_W, tick divider; one tick every prescale+1 enabled cycles.
REQ-013 SHALL have port count, output, WIDTH, current count (registered).
REQ-014 SHALL have port tc, output, 1, terminal-count pulse (registered).
REQ-015 SHALL have port ovf, output, 1, sticky wrap flag (registered).

Function
REQ-016 SHALL keep an internal prescaler counter pcnt (PRESCALE_W bits); when en=1: if pcnt==prescale, assert internal tick and set pcnt to 0, else increment pcnt; when en=0: hold pcnt, no tick.
REQ-017 SHALL use the priority clr > load > tick > hold on every rising edge.
REQ-018 SHALL on clr=1 set count=0, pcnt=0, tc=0, ovf=0, regardless of all other inputs.
REQ-019 SHALL on load=1 (clr=0) set count=load_val and pcnt=0, without tick, tc or ovf effect; load_val > max_val is accepted unchanged.
REQ-020 SHALL on tick, up, count < max_val: count+1.
REQ-021 SHALL on tick, up, count >= max_val: wrap mode -> count=0 and ovf=1; saturate mode -> count=max_val.
REQ-022 SHALL on tick, down, count > max_val: wrap mode -> count=max_val and ovf=1; saturate mode -> count=max_val.
REQ-023 SHALL on tick, down, 0 < count <= max_val: count-1.
REQ-024 SHALL on tick, down, count==0: wrap mode -> count=max_val and ovf=1; saturate mode -> hold 0.
REQ-025 SHALL assert tc for exactly the cycle after any tick where the pre-tick count was at the boundary (>=max_val up, ==0 down), in both modes; tc=0 otherwise.
REQ-026 SHALL hold ovf at 1 once set, until clr or reset.
REQ-027 SHALL evaluate dir, mode, max_val and prescale combinationally per cycle; changes take effect at the next edge without corrupting state.
REQ-028 SHALL treat max_val=0 as valid: up/wrap gives count 0 every tick, with tc and ovf set.
REQ-029 SHALL produce no X on outputs for any input combination after reset.

Reset
REQ-030 SHALL on rst=0 asynchronously set count=0, pcnt=0, tc=0, ovf=0, held while rst=0.
REQ-031 SHALL resume normal operation from the first rising clk edge after rst deasserts.

Verification
REQ-032 Bench SHALL cover basic wrap: WIDTH=8, max_val=5, prescale=0, dir=1, mode=0, en=1 for 7 cycles -> count 1,2,3,4,5,0,1; tc high one cycle after 5->0; ovf=1.
REQ-033 Bench SHALL cover saturate down: load 2, mode=1, dir=0, prescale=0 -> count 1,0,0,0; tc pulses on each tick at 0; ovf stays 0.
REQ-034 Bench SHALL cover the prescaler: prescale=3, en=1, up from 0 -> count increments every 4th cycle; en=0 for 5 cycles mid-period -> count and phase frozen.
REQ-035 Bench SHALL cover priority: clr=1 and load=1 with load_val=9 in the same cycle -> count=0, ovf=0; load=1 alone with load_val=200, max_val=10, up, wrap -> next tick count=0, ovf=1.
REQ-036 Bench SHALL cover async reset mid-count: rst low between edges at count=7 -> count=0, tc=0, ovf=0 immediately; counting restarts from 0 after release.
